// File: rtl/life_ctrl.sv
// life_ctrl: key-driven sequencer for the Game of Life core.
// Cursor moves, cell flips and generation steps with auto-repeat.
module life_ctrl #(
  parameter int X = 16,
  parameter int Y = 16,
  parameter int LOG2X = 4,
  parameter int LOG2Y = 4,
  parameter int HOLD = 256,
  parameter int REPEAT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_nxt,
  input  logic             key_flip,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_left,
  input  logic             key_right,
  output logic             eng_start,
  input  logic             eng_done,
  output logic             flip_req,
  output logic [LOG2X-1:0] flip_x,
  output logic [LOG2Y-1:0] flip_y,
  input  logic             flip_ack,
  output logic [LOG2X-1:0] cur_x,
  output logic [LOG2Y-1:0] cur_y,
  output logic             busy,
  output logic [15:0]      gen_count
);

  localparam int MAXP = (HOLD > REPEAT) ? HOLD : REPEAT;
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD - 1);
  localparam logic [CW-1:0] REP_LIM = CW'(REPEAT - 1);
  localparam logic [LOG2X-1:0] XMAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YMAX = LOG2Y'(Y - 1);
  localparam logic [LOG2X-1:0] XMID = LOG2X'(X / 2);
  localparam logic [LOG2Y-1:0] YMID = LOG2Y'(Y / 2);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    FLIP
  } state_t;

  state_t state, state_n;

  logic [5:0] keys, k_q, rise;
  logic [CW-1:0] cnt;
  logic rep;
  logic tick;
  logic flip_pend, step_pend;
  logic flip_ev, step_ev;
  logic flip_go, step_go;
  logic [LOG2X-1:0] x_n;
  logic [LOG2Y-1:0] y_n;

  assign keys = {key_nxt, key_flip, key_up,
                 key_down, key_left, key_right};
  assign rise = keys & ~k_q;

  // rep selects the shorter spacing once the first hold tick has fired
  assign tick = key_nxt &&
                (cnt == (rep ? REP_LIM : HOLD_LIM));

  assign flip_ev = rise[4];
  assign step_ev = rise[5] | tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
      cnt <= '0;
      rep <= 1'b0;
    end else begin
      k_q <= keys;
      if (!key_nxt) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (tick) begin
        cnt <= '0;
        rep <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    x_n = cur_x;
    y_n = cur_y;
    if (rise[1] && !rise[0])
      x_n = (cur_x == '0) ? XMAX : cur_x - LOG2X'(1);
    else if (rise[0] && !rise[1])
      x_n = (cur_x == XMAX) ? '0 : cur_x + LOG2X'(1);
    if (rise[3] && !rise[2])
      y_n = (cur_y == '0) ? YMAX : cur_y - LOG2Y'(1);
    else if (rise[2] && !rise[3])
      y_n = (cur_y == YMAX) ? '0 : cur_y + LOG2Y'(1);
  end

  always_comb begin
    state_n = state;
    flip_go = 1'b0;
    step_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (flip_ev || flip_pend) begin
          state_n = FLIP;
          flip_go = 1'b1;
        end else if (step_ev || step_pend) begin
          state_n = STEP;
          step_go = 1'b1;
        end
      end
      STEP: if (eng_done) state_n = IDLE;
      FLIP: if (flip_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_start <= 1'b0;
      flip_req  <= 1'b0;
      busy      <= 1'b0;
      flip_x    <= '0;
      flip_y    <= '0;
      cur_x     <= XMID;
      cur_y     <= YMID;
      gen_count <= '0;
      flip_pend <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      eng_start <= step_go;
      flip_req  <= (state_n == FLIP);
      busy      <= (state_n != IDLE);
      cur_x     <= x_n;
      cur_y     <= y_n;
      // target is the pre-move cursor, frozen until the ack
      if (flip_go) begin
        flip_x <= cur_x;
        flip_y <= cur_y;
      end
      if (state == STEP && eng_done)
        gen_count <= gen_count + 16'd1;
      flip_pend <= !flip_go && (flip_pend || flip_ev);
      step_pend <= !step_go && (step_pend || step_ev);
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: directed vector bench for life_ctrl.
// Cursor table plus hand sequences for step, flip, repeat and reset.
module tb_life_ctrl;

  localparam int HOLD = 16;
  localparam int REPEAT = 8;

  localparam logic [5:0] K_NXT = 6'b100000;
  localparam logic [5:0] K_FLP = 6'b010000;
  localparam logic [5:0] K_UP  = 6'b001000;
  localparam logic [5:0] K_DN  = 6'b000100;
  localparam logic [5:0] K_L   = 6'b000010;
  localparam logic [5:0] K_R   = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_nxt = 1'b0, key_flip = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0;
  logic key_left = 1'b0, key_right = 1'b0;
  logic eng_done = 1'b0, flip_ack = 1'b0;
  logic eng_start, flip_req, busy;
  logic [3:0] flip_x, flip_y, cur_x, cur_y;
  logic [15:0] gen_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] keys;
    logic [3:0] ex;
    logic [3:0] ey;
    string      name;
  } vec_t;

  vec_t vecs[$];

  life_ctrl #(
    .X(16), .Y(16), .LOG2X(4), .LOG2Y(4),
    .HOLD(HOLD), .REPEAT(REPEAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_nxt(key_nxt),
    .key_flip(key_flip),
    .key_up(key_up),
    .key_down(key_down),
    .key_left(key_left),
    .key_right(key_right),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .flip_req(flip_req),
    .flip_x(flip_x),
    .flip_y(flip_y),
    .flip_ack(flip_ack),
    .cur_x(cur_x),
    .cur_y(cur_y),
    .busy(busy),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [5:0] k);
    {key_nxt, key_flip, key_up,
     key_down, key_left, key_right} = k;
  endtask

  task automatic add(input logic [5:0] k, input int x,
                     input int y, input string n);
    vec_t v;
    v.keys = k;
    v.ex = 4'(x);
    v.ey = 4'(y);
    v.name = n;
    vecs.push_back(v);
  endtask

  task automatic do_reset(input string tag);
    set_keys('0);
    eng_done = 1'b0;
    flip_ack = 1'b0;
    reset = 1'b0;
    step_clk();
    step_clk();
    reset = 1'b1;
    step_clk();
    chk({tag, "_cur_x"}, 16'(cur_x), 16'd8);
    chk({tag, "_cur_y"}, 16'(cur_y), 16'd8);
    chk({tag, "_gen"}, gen_count, 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_start"}, 16'(eng_start), 16'd0);
    chk({tag, "_freq"}, 16'(flip_req), 16'd0);
  endtask

  initial begin
    int starts;
    int busy_cnt;
    logic e;

    for (int i = 1; i <= 8; i++)
      add(K_R, (8 + i) % 16, 8, "right");
    add(K_L, 15, 8, "left_wrap");
    add(K_R, 0, 8, "right_wrap");
    for (int i = 1; i <= 8; i++)
      add(K_UP, 0, 8 - i, "up");
    add(K_UP, 0, 15, "up_wrap");
    add(K_DN, 0, 0, "down_wrap");
    add(K_L | K_R, 0, 0, "lr_same");
    add(K_UP | K_DN, 0, 0, "ud_same");
    add(K_L | K_R | K_UP, 0, 15, "lr_up");
    add(K_DN | K_R, 1, 0, "down_right");
    add(K_L, 0, 0, "left");

    do_reset("rst0");

    foreach (vecs[i]) begin
      set_keys(vecs[i].keys);
      step_clk();
      chk($sformatf("%s[%0d]_x", vecs[i].name, i),
          16'(cur_x), 16'(vecs[i].ex));
      chk($sformatf("%s[%0d]_y", vecs[i].name, i),
          16'(cur_y), 16'(vecs[i].ey));
      chk($sformatf("%s[%0d]_busy", vecs[i].name, i),
          16'(busy), 16'd0);
      set_keys('0);
      step_clk();
    end

    // single step, engine answers 20 cycles after start
    key_nxt = 1'b1;
    step_clk();
    chk("step_start", 16'(eng_start), 16'd1);
    key_nxt = 1'b0;
    starts = 1;
    busy_cnt = int'(busy);
    for (int i = 1; i < 20; i++) begin
      step_clk();
      starts += int'(eng_start);
      busy_cnt += int'(busy);
      if (i == 19) eng_done = 1'b1;
    end
    step_clk();
    eng_done = 1'b0;
    chk("step_busy_after", 16'(busy), 16'd0);
    chk("step_gen", gen_count, 16'd1);
    for (int i = 0; i < 5; i++) begin
      step_clk();
      starts += int'(eng_start);
    end
    chk("step_starts", 16'(starts), 16'd1);
    chk("step_busy_cycles", 16'(busy_cnt), 16'd20);

    do_reset("rst1");

    // flip and step rise together
    set_keys(K_FLP | K_NXT);
    step_clk();
    chk("col_freq", 16'(flip_req), 16'd1);
    chk("col_start0", 16'(eng_start), 16'd0);
    chk("col_fx", 16'(flip_x), 16'd8);
    chk("col_fy", 16'(flip_y), 16'd8);
    set_keys(K_R);
    step_clk();
    set_keys('0);
    chk("col_cur_x", 16'(cur_x), 16'd9);
    chk("col_fx_hold", 16'(flip_x), 16'd8);
    chk("col_freq_hold", 16'(flip_req), 16'd1);
    step_clk();
    flip_ack = 1'b1;
    step_clk();
    flip_ack = 1'b0;
    chk("col_freq_drop", 16'(flip_req), 16'd0);
    chk("col_start_gap", 16'(eng_start), 16'd0);
    step_clk();
    chk("col_start", 16'(eng_start), 16'd1);
    eng_done = 1'b1;
    step_clk();
    eng_done = 1'b0;
    chk("col_busy", 16'(busy), 16'd0);
    chk("col_gen", gen_count, 16'd1);

    // stray done in IDLE
    eng_done = 1'b1;
    step_clk();
    eng_done = 1'b0;
    chk("stray_gen", gen_count, 16'd1);
    chk("stray_busy", 16'(busy), 16'd0);
    step_clk();

    // auto-repeat with an instant engine
    key_nxt = 1'b1;
    for (int c = 0; c < 48; c++) begin
      step_clk();
      eng_done = eng_start;
      e = (c == 0) || (c == 15) || (c == 23) ||
          (c == 31) || (c == 39);
      chk($sformatf("rep_start@%0d", c),
          16'(eng_start), 16'(e));
      if (c == 39) key_nxt = 1'b0;
    end
    eng_done = 1'b0;
    chk("rep_gen", gen_count, 16'd6);

    // asynchronous reset while the engine is running
    key_nxt = 1'b1;
    step_clk();
    chk("mid_start", 16'(eng_start), 16'd1);
    key_nxt = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_start_drop", 16'(eng_start), 16'd0);
    chk("mid_busy_drop", 16'(busy), 16'd0);
    step_clk();
    step_clk();
    reset = 1'b1;
    eng_done = 1'b1;
    step_clk();
    eng_done = 1'b0;
    chk("stale_gen", gen_count, 16'd0);
    chk("stale_busy", 16'(busy), 16'd0);
    step_clk();
    chk("stale_gen2", gen_count, 16'd0);
    key_nxt = 1'b1;
    step_clk();
    key_nxt = 1'b0;
    chk("post_start", 16'(eng_start), 16'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
